w5300_bus_seq: RTL and testbench

W5300_BUS_SEQ -- requirements
Module: w5300_bus_seq

---
 rtl/w5300_pkg.sv | 32 +++
 rtl/w5300_bus_seq_sync2.sv | 24 ++
 rtl/w5300_bus_seq.sv | 165 ++++++++++++++++
 tb/tb_w5300_bus_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_pkg.sv
// Shared types, address-map constants and the Z80-to-W5300 address translation
// used by the W5300 bus sequencer.
package w5300_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_WAIT_END
  } state_e;

  localparam logic [13:0] REGION_MID = 14'h2000;
  localparam logic [13:0] REGION_HI  = 14'h3000;
  localparam logic [4:0]  MID_TAG    = 5'b10111;
  localparam logic [4:0]  HI_TAG     = 5'b11000;

  // Low 8K maps straight through; the two upper 4K regions fold onto fixed register blocks.
  function automatic logic [9:0] map_addr(input logic [13:0] m, input logic a0_inv);
    logic [9:0] r;
    if (m < REGION_MID) begin
      r = m[9:0];
    end else if (m < REGION_HI) begin
      r = {1'b1, m[11:9], MID_TAG, m[0]};
    end else begin
      r = {1'b1, m[11:9], HI_TAG, m[0]};
    end
    r[0] = r[0] ^ a0_inv;
    return r;
  endfunction

endpackage

// File: rtl/w5300_bus_seq_sync2.sv
// Two-flop synchronizer for an asynchronous active-low strobe; resets to the inactive level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/w5300_bus_seq.sv
// Translates Z80 ROM-window accesses into timed W5300 bus cycles (setup/active/hold),
// latching address, direction and data at the start so the access is self-contained.
module w5300_bus_seq
  import w5300_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int ACTIVE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  input  logic        zmreq_n,
  input  logic        zrd_n,
  input  logic        zwr_n,
  input  logic        zcsrom_n,
  input  logic [1:0]  cfg_rom,
  input  logic        cfg_sub_ena,
  input  logic        cfg_a0_inv,
  output logic [9:0]  w5300_addr,
  output logic        w5300_cs_n,
  output logic        brd_n,
  output logic        bwr_n,
  output logic [7:0]  bd_out,
  output logic        bd_oe,
  input  logic [7:0]  bd_in,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  output logic        zblkrom,
  output logic        busy
);

  localparam logic [2:0] SETUP_LAST  = 3'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [2:0] ACTIVE_LAST = 3'(ACTIVE_CYC - 1);
  localparam logic [2:0] HOLD_LAST   = 3'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  logic [3:0] async_n;
  logic [3:0] sync_n;
  logic       mreq_s, rd_s, wr_s, csrom_s;

  assign async_n = {zcsrom_n, zwr_n, zrd_n, zmreq_n};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (async_n[gi]),
        .q   (sync_n[gi])
      );
    end
  endgenerate

  assign mreq_s  = sync_n[0];
  assign rd_s    = sync_n[1];
  assign wr_s    = sync_n[2];
  assign csrom_s = sync_n[3];

  logic win_match, hit, start;

  assign win_match = (za[15:14] == cfg_rom);
  assign zblkrom   = win_match && cfg_sub_ena;
  assign hit       = !mreq_s && !csrom_s && win_match && cfg_sub_ena;
  // A simultaneous read and write is ambiguous, so it never starts a cycle.
  assign start     = hit && (rd_s ^ wr_s);

  state_e     state_q, state_d;
  logic [2:0] cnt_q;
  logic [9:0] addr_q;
  logic       is_rd_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       rd_valid_q;
  logic       rd_capture;

  assign rd_capture = (state_q == ST_ACTIVE) && (cnt_q == ACTIVE_LAST) && is_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 10'd0;
      is_rd_q    <= 1'b0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
      if (state_q == ST_IDLE && start) begin
        addr_q  <= map_addr(za[13:0], cfg_a0_inv);
        is_rd_q <= !rd_s;
        if (!wr_s) begin
          wdata_q <= zd_in;
        end
      end
      if (rd_capture) begin
        rdata_q    <= bd_in;
        rd_valid_q <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (SETUP_CYC > 0) ? ST_SETUP : ST_ACTIVE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == ACTIVE_LAST) begin
          state_d = (HOLD_CYC > 0) ? ST_HOLD : ST_WAIT_END;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (mreq_s || (rd_s && wr_s)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w5300_cs_n = 1'b1;
    brd_n      = 1'b1;
    bwr_n      = 1'b1;
    bd_oe      = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_SETUP, ST_HOLD: begin
        w5300_cs_n = 1'b0;
        bd_oe      = !is_rd_q;
      end
      ST_ACTIVE: begin
        w5300_cs_n = 1'b0;
        bd_oe      = !is_rd_q;
        brd_n      = !is_rd_q;
        bwr_n      = is_rd_q;
      end
      default: ;
    endcase
  end

  assign w5300_addr = addr_q;
  assign bd_out     = wdata_q;
  assign zd_out     = rdata_q;
  assign zd_oe      = rd_valid_q;

endmodule

// File: tb/tb_w5300_bus_seq.sv
// Self-checking bench for w5300_bus_seq: directed table, random transactions against a
// transaction-level model, and hand-written reset / strobe-release sequences.
module tb_w5300_bus_seq;

  localparam int S = 1;
  localparam int A = 3;
  localparam int H = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] za;
  logic [7:0]  zd_in, bd_in;
  logic        zmreq_n, zrd_n, zwr_n, zcsrom_n;
  logic [1:0]  cfg_rom;
  logic        cfg_sub_ena, cfg_a0_inv;

  logic [9:0]  w5300_addr, w5300_addr2;
  logic        w5300_cs_n, brd_n, bwr_n, bd_oe, zd_oe, zblkrom, busy;
  logic        w5300_cs_n2, brd_n2, bwr_n2, bd_oe2, zd_oe2, zblkrom2, busy2;
  logic [7:0]  bd_out, zd_out, bd_out2, zd_out2;

  w5300_bus_seq dut (
    .clk(clk), .rst(rst), .za(za), .zd_in(zd_in),
    .zmreq_n(zmreq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zcsrom_n(zcsrom_n),
    .cfg_rom(cfg_rom), .cfg_sub_ena(cfg_sub_ena), .cfg_a0_inv(cfg_a0_inv),
    .w5300_addr(w5300_addr), .w5300_cs_n(w5300_cs_n), .brd_n(brd_n), .bwr_n(bwr_n),
    .bd_out(bd_out), .bd_oe(bd_oe), .bd_in(bd_in), .zd_out(zd_out), .zd_oe(zd_oe),
    .zblkrom(zblkrom), .busy(busy)
  );

  w5300_bus_seq #(.SETUP_CYC(2), .ACTIVE_CYC(3), .HOLD_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .za(za), .zd_in(zd_in),
    .zmreq_n(zmreq_n), .zrd_n(zrd_n), .zwr_n(zwr_n), .zcsrom_n(zcsrom_n),
    .cfg_rom(cfg_rom), .cfg_sub_ena(cfg_sub_ena), .cfg_a0_inv(cfg_a0_inv),
    .w5300_addr(w5300_addr2), .w5300_cs_n(w5300_cs_n2), .brd_n(brd_n2), .bwr_n(bwr_n2),
    .bd_out(bd_out2), .bd_oe(bd_oe2), .bd_in(bd_in), .zd_out(zd_out2), .zd_oe(zd_oe2),
    .zblkrom(zblkrom2), .busy(busy2)
  );

  typedef struct {
    logic [15:0] za;
    logic [7:0]  zd;
    bit          do_rd;
    bit          do_wr;
    logic        csrom_n;
    logic [1:0]  rom;
    bit          ena;
    bit          inv;
    logic [7:0]  bdi;
    bit          flip;
    logic [9:0]  e_addr;
    int          e_cs;
    int          e_rd;
    int          e_wr;
    int          e_oe;
    bit          e_blk;
    logic [7:0]  e_zd;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Address translation written as plain arithmetic on the 16K window offset.
  function automatic logic [9:0] ref_map(input logic [15:0] a, input bit inv);
    int m, r;
    m = int'(a) % 16384;
    if (m < 8192) r = m % 1024;
    else r = 512 + ((m / 512) % 8) * 64 + ((m < 12288) ? 23 : 24) * 2 + (m % 2);
    if (inv) r = (r % 2 == 1) ? r - 1 : r + 1;
    return 10'(r);
  endfunction

  // Transaction-level expectations: whether a cycle runs and how long each strobe lasts.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   started;
    r       = v;
    started = v.ena && (v.csrom_n == 1'b0) && (v.za[15:14] == v.rom) && (v.do_rd != v.do_wr);
    r.e_blk  = v.ena && (v.za[15:14] == v.rom);
    r.e_addr = ref_map(v.za, v.inv);
    r.e_cs   = started ? S + A + H : 0;
    r.e_rd   = (started && v.do_rd) ? A : 0;
    r.e_wr   = (started && v.do_wr) ? A : 0;
    r.e_oe   = (started && v.do_wr) ? S + A + H : 0;
    r.e_zd   = v.bdi;
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic [7:0] d, input bit rd, input bit wr,
                              input logic cs_n, input logic [1:0] rom, input bit ena, input bit inv,
                              input logic [7:0] bdi, input logic [9:0] e_addr, input int e_cs,
                              input int e_rd, input int e_wr, input int e_oe, input bit e_blk,
                              input logic [7:0] e_zd);
    vec_t v;
    v.za = a; v.zd = d; v.do_rd = rd; v.do_wr = wr; v.csrom_n = cs_n; v.rom = rom;
    v.ena = ena; v.inv = inv; v.bdi = bdi; v.flip = 1'b0; v.e_addr = e_addr;
    v.e_cs = e_cs; v.e_rd = e_rd; v.e_wr = e_wr; v.e_oe = e_oe; v.e_blk = e_blk; v.e_zd = e_zd;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input string tag);
    int         ncs = 0, nrd = 0, nwr = 0, noe = 0, nout = 0;
    bit         unstable = 1'b0, seen = 1'b0;
    logic [9:0] cap_a = '0;
    logic [7:0] cap_bd = '0, zd_pre = '0;
    logic       blk = 1'b0, zdoe_pre = 1'b0;
    @(negedge clk);
    cfg_rom = v.rom; cfg_sub_ena = v.ena; cfg_a0_inv = v.inv;
    za = v.za; zd_in = v.zd; bd_in = v.bdi; zcsrom_n = v.csrom_n;
    zmreq_n = 1'b0; zrd_n = !v.do_rd; zwr_n = !v.do_wr;
    for (int c = 0; c < 31; c++) begin
      if (c == 25) begin
        zdoe_pre = zd_oe; zd_pre = zd_out;
        zmreq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zcsrom_n = 1'b1;
      end
      @(negedge clk);
      if (c == 0) blk = zblkrom;
      if (!w5300_cs_n) begin
        ncs++;
        if (seen && w5300_addr != cap_a) unstable = 1'b1;
        cap_a = w5300_addr;
        seen  = 1'b1;
      end
      if (!brd_n) nrd++;
      if (!bwr_n) begin
        nwr++;
        cap_bd = bd_out;
      end
      if (bd_oe) noe++;
      if ((!brd_n || !bwr_n || bd_oe) && w5300_cs_n) nout++;
      if (v.flip && c == 5) begin
        cfg_a0_inv  = !cfg_a0_inv;
        cfg_sub_ena = !cfg_sub_ena;
        cfg_rom     = cfg_rom + 2'd1;
      end
    end
    check({tag, ".cs_cycles"}, ncs, v.e_cs);
    check({tag, ".brd_cycles"}, nrd, v.e_rd);
    check({tag, ".bwr_cycles"}, nwr, v.e_wr);
    check({tag, ".bd_oe_cycles"}, noe, v.e_oe);
    check({tag, ".zblkrom"}, blk, v.e_blk);
    check({tag, ".strobe_outside_cs"}, nout, 0);
    if (v.e_cs > 0) begin
      check({tag, ".w5300_addr"}, cap_a, v.e_addr);
      check({tag, ".addr_stable"}, unstable, 0);
    end
    if (v.e_wr > 0) check({tag, ".bd_out"}, cap_bd, v.zd);
    check({tag, ".zd_oe_before_release"}, zdoe_pre, (v.e_rd > 0));
    if (v.e_rd > 0) check({tag, ".zd_out"}, zd_pre, v.e_zd);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".zd_oe_after"}, zd_oe, 0);
    $display("txn %s za=%h rd=%0d wr=%0d rom=%0d ena=%0d inv=%0d cs=%0d addr=%h", tag, v.za,
             v.do_rd, v.do_wr, v.rom, v.ena, v.inv, ncs, cap_a);
  endtask

  vec_t tbl[12];
  vec_t rv;
  bit   found;
  int   ncs2, nwr2, nrd2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(16'h0123, 8'h5A, 0, 1, 0, 2'd0, 1, 0, 8'h00, 10'h123, 5, 0, 3, 5, 1, 8'h00);
    tbl[1]  = mk(16'hA801, 8'h00, 1, 0, 0, 2'd2, 1, 1, 8'hC3, 10'h32E, 5, 3, 0, 0, 1, 8'hC3);
    tbl[2]  = mk(16'h0010, 8'h11, 0, 1, 0, 2'd1, 1, 0, 8'h00, 10'h010, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = mk(16'h3E05, 8'h00, 1, 0, 0, 2'd0, 1, 0, 8'h7E, 10'h3F1, 5, 3, 0, 0, 1, 8'h7E);
    tbl[4]  = mk(16'h0123, 8'h00, 1, 0, 0, 2'd0, 0, 0, 8'h55, 10'h123, 0, 0, 0, 0, 0, 8'h00);
    tbl[5]  = mk(16'h4123, 8'h00, 1, 0, 1, 2'd1, 1, 0, 8'h55, 10'h123, 0, 0, 0, 0, 1, 8'h00);
    tbl[6]  = mk(16'h0123, 8'h77, 1, 1, 0, 2'd0, 1, 0, 8'h55, 10'h123, 0, 0, 0, 0, 1, 8'h00);
    tbl[7]  = mk(16'h1FFF, 8'h00, 1, 0, 0, 2'd0, 1, 0, 8'h01, 10'h3FF, 5, 3, 0, 0, 1, 8'h01);
    tbl[8]  = mk(16'h6000, 8'hA5, 0, 1, 0, 2'd1, 1, 1, 8'h00, 10'h22F, 5, 0, 3, 5, 1, 8'h00);
    tbl[9]  = mk(16'hEFFF, 8'h00, 1, 0, 0, 2'd3, 1, 0, 8'h3C, 10'h3EF, 5, 3, 0, 0, 1, 8'h3C);
    tbl[10] = mk(16'hB000, 8'h0F, 0, 1, 0, 2'd2, 1, 0, 8'h00, 10'h230, 5, 0, 3, 5, 1, 8'h00);
    tbl[11] = mk(16'h3FFF, 8'h00, 1, 0, 0, 2'd0, 1, 1, 8'h99, 10'h3F0, 5, 3, 0, 0, 1, 8'h99);

    rst = 1'b1; za = '0; zd_in = '0; bd_in = '0;
    zmreq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zcsrom_n = 1'b1;
    cfg_rom = 2'd0; cfg_sub_ena = 1'b0; cfg_a0_inv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.dut", {w5300_cs_n, brd_n, bwr_n, bd_oe, zd_oe, busy, zd_out, bd_out, w5300_addr},
          {6'b111000, 8'h00, 8'h00, 10'h000});
    check("reset.dut2", {w5300_cs_n2, brd_n2, bwr_n2, bd_oe2, zd_oe2, busy2, zd_out2, bd_out2, w5300_addr2},
          {6'b111000, 8'h00, 8'h00, 10'h000});

    for (int i = 0; i < 12; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.rom = 2'($urandom_range(0, 3));
      rv.za  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rv.za[15:14] = rv.rom;
      rv.zd      = 8'($urandom);
      rv.bdi     = 8'($urandom);
      rv.ena     = ($urandom_range(0, 7) != 0);
      rv.inv     = 1'($urandom_range(0, 1));
      rv.csrom_n = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0:          begin rv.do_rd = 1'b1; rv.do_wr = 1'b1; end
        1, 2, 3, 4: begin rv.do_rd = 1'b1; rv.do_wr = 1'b0; end
        default:    begin rv.do_rd = 1'b0; rv.do_wr = 1'b1; end
      endcase
      rv.flip = 1'b0;
      rv = model(rv);
      if (rv.e_cs > 0) rv.flip = 1'($urandom_range(0, 1));
      do_txn(rv, $sformatf("rnd%0d", i));
    end

    // Reset landing in the second ACTIVE cycle of a write must drop everything at once.
    @(negedge clk);
    cfg_rom = 2'd0; cfg_sub_ena = 1'b1; cfg_a0_inv = 1'b0;
    za = 16'h0200; zd_in = 8'h3C; zcsrom_n = 1'b0; zmreq_n = 1'b0; zrd_n = 1'b1; zwr_n = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bwr_n) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid.active_seen", found, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid.second_active", bwr_n, 0);
    @(negedge clk);
    check("rst_mid.strobes", {w5300_cs_n, brd_n, bwr_n, bd_oe, zd_oe, busy}, 6'b111000);
    check("rst_mid.regs", {zd_out, bd_out, w5300_addr}, {8'h00, 8'h00, 10'h000});
    zmreq_n = 1'b1; zwr_n = 1'b1; zcsrom_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid.idle_after", {busy, w5300_cs_n, bwr_n}, 3'b011);
    $display("txn rst_mid found=%0d", found);

    // Strobes released during SETUP (2-cycle setup) must still yield the full access.
    @(negedge clk);
    za = 16'h0040; zd_in = 8'hE1; zcsrom_n = 1'b0; zmreq_n = 1'b0; zrd_n = 1'b1; zwr_n = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!w5300_cs_n2) begin
        found = 1'b1;
        break;
      end
    end
    check("release.setup_seen", found, 1);
    zmreq_n = 1'b1; zwr_n = 1'b1; zcsrom_n = 1'b1;
    ncs2 = found ? 1 : 0;
    nwr2 = 0;
    nrd2 = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (!w5300_cs_n2) ncs2++;
      if (!bwr_n2) nwr2++;
      if (!brd_n2) nrd2++;
    end
    check("release.cs_cycles", ncs2, 6);
    check("release.bwr_cycles", nwr2, 3);
    check("release.brd_cycles", nrd2, 0);
    check("release.idle", busy2, 0);
    $display("txn release cs=%0d bwr=%0d", ncs2, nwr2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
